// File: rtl/sfq_pulse_deser.sv
// sfq_pulse_deser
//   Capture stage for the confluence-buffer pulse output (ABO). Samples the
//   pulse level once per TI cycle (pulse = 1, no pulse = 0), assembles
//   WIDTH-bit words aligned to the frame marker FI and presents each complete
//   word on a valid/ready output register. It also keeps a saturating count of
//   captured ones for link bring-up.
//
// Parameters
//   WIDTH  word length in bits (>= 2)
//   CNT_W  width of the ones counter
//
// Ports
//   TI   in   clock, all logic on its rising edge
//   RI   in   synchronous active-high reset
//   AI   in   sampled pulse level (1 = pulse present this cycle)
//   FI   in   frame marker, high on the cycle whose AI is bit 0 of a word
//   RDI  in   consumer ready
//   DO   out  assembled word
//   VO   out  DO valid
//   OVO  out  sticky overflow, a completed word was dropped
//   CO   out  saturating count of captured AI=1 samples
//
// Configuration
//   SFQ_PULSE_DESER_MSB_FIRST_EN  defined: the first captured bit lands in
//   DO[WIDTH-1]. Undefined (default): the first captured bit lands in DO[0].

module sfq_pulse_deser #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             TI,
   input  logic             RI,
   input  logic             AI,
   input  logic             FI,
   input  logic             RDI,
   output logic [WIDTH-1:0] DO,
   output logic             VO,
   output logic             OVO,
   output logic [CNT_W-1:0] CO
);

   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      COLLECT
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] do_q, do_d;
   logic             vo_q, vo_d;
   logic             ovo_q, ovo_d;
   logic [CNT_W-1:0] co_q, co_d;

   logic             capture;
   logic             complete;
   logic             out_free;
   logic [IW-1:0]    pos;
   logic [IW-1:0]    bit_sel;
   logic [WIDTH-1:0] word;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      sr_d     = sr_q;
      do_d     = do_q;
      vo_d     = vo_q;
      ovo_d    = ovo_q;
      co_d     = co_q;

      // FI always restarts the word at bit 0, in IDLE or mid-word.
      capture  = (state_q == COLLECT) || FI;
      pos      = FI ? '0 : idx_q;
`ifdef SFQ_PULSE_DESER_MSB_FIRST_EN
      bit_sel  = LAST - pos;
`else
      bit_sel  = pos;
`endif
      word           = FI ? '0 : sr_q;
      word[bit_sel]  = AI;

      // A resync on the last index wins: no word is emitted.
      complete = capture && !FI && (idx_q == LAST);
      out_free = !vo_q || RDI;

      if (capture) begin
         state_d = COLLECT;
         sr_d    = word;
         idx_d   = complete ? '0 : pos + IW'(1);
         if (AI && (co_q != '1)) begin
            co_d = co_q + CNT_W'(1);
         end
      end

      if (complete) begin
         if (out_free) begin
            do_d = word;
            vo_d = 1'b1;
         end else begin
            ovo_d = 1'b1;
         end
      end else if (vo_q && RDI) begin
         vo_d = 1'b0;
      end
   end

   always_ff @(posedge TI) begin
      if (RI) begin
         state_q <= IDLE;
         idx_q   <= '0;
         sr_q    <= '0;
         do_q    <= '0;
         vo_q    <= 1'b0;
         ovo_q   <= 1'b0;
         co_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sr_q    <= sr_d;
         do_q    <= do_d;
         vo_q    <= vo_d;
         ovo_q   <= ovo_d;
         co_q    <= co_d;
      end
   end

   assign DO  = do_q;
   assign VO  = vo_q;
   assign OVO = ovo_q;
   assign CO  = co_q;

endmodule

// File: tb/tb_sfq_pulse_deser.sv
// tb_sfq_pulse_deser
//   Bench for sfq_pulse_deser (WIDTH=8, CNT_W=16) plus a second instance with
//   CNT_W=3 so counter saturation is reached within a few frames. A queue-based
//   reference model predicts every output each cycle; directed scenarios add
//   fixed expected values on top. Honours SFQ_PULSE_DESER_MSB_FIRST_EN.

module tb_sfq_pulse_deser;

   logic       clk = 1'b0;
   logic       ri, ai, fi, rdi;
   logic [7:0] do_w;
   logic       vo_w, ovo_w;
   logic [15:0] co_w;
   logic [7:0] do_s;
   logic       vo_s, ovo_s;
   logic [2:0] co_s;

   int checks = 0;
   int errors = 0;

`ifdef SFQ_PULSE_DESER_MSB_FIRST_EN
   localparam logic [7:0] EXP_S1 = 8'hB1;
   localparam logic [7:0] EXP_RS = 8'h55;
`else
   localparam logic [7:0] EXP_S1 = 8'h8D;
   localparam logic [7:0] EXP_RS = 8'hAA;
`endif

   always #5 clk = ~clk;

   sfq_pulse_deser #(.WIDTH(8), .CNT_W(16)) dut (
      .TI(clk), .RI(ri), .AI(ai), .FI(fi), .RDI(rdi),
      .DO(do_w), .VO(vo_w), .OVO(ovo_w), .CO(co_w)
   );

   sfq_pulse_deser #(.WIDTH(8), .CNT_W(3)) dut_sat (
      .TI(clk), .RI(ri), .AI(ai), .FI(fi), .RDI(rdi),
      .DO(do_s), .VO(vo_s), .OVO(ovo_s), .CO(co_s)
   );

   // Reference model: captured bits collect in a queue; eight bits make a word.
   bit         m_bits[$];
   bit         m_in_frame;
   logic [7:0] m_do;
   bit         m_vo, m_ovo;
   int         m_cnt;

   task automatic model_update(input bit r, input bit a, input bit f, input bit rd);
      bit         done;
      bit         free;
      logic [7:0] w;
      done = 0;
      w    = '0;
      if (r) begin
         m_bits.delete();
         m_in_frame = 0;
         m_do  = '0;
         m_vo  = 0;
         m_ovo = 0;
         m_cnt = 0;
      end else begin
         free = !m_vo || rd;
         if (f) begin
            m_bits.delete();
            m_in_frame = 1;
         end
         if (m_in_frame) begin
            m_bits.push_back(a);
            if (a) m_cnt++;
         end
         if (m_bits.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
`ifdef SFQ_PULSE_DESER_MSB_FIRST_EN
               w[7-i] = m_bits[i];
`else
               w[i] = m_bits[i];
`endif
            end
            m_bits.delete();
            done = 1;
         end
         if (done) begin
            if (free) begin
               m_do = w;
               m_vo = 1;
            end else begin
               m_ovo = 1;
            end
         end else if (m_vo && rd) begin
            m_vo = 0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, advance model, sample #1 after the edge.
   task automatic step(input bit r, input bit a, input bit f, input bit rd);
      ri  = r;
      ai  = a;
      fi  = f;
      rdi = rd;
      model_update(r, a, f, rd);
      @(posedge clk);
      #1;
      chk("DO", 32'(do_w), 32'(m_do));
      chk("VO", 32'(vo_w), 32'(m_vo));
      chk("OVO", 32'(ovo_w), 32'(m_ovo));
      chk("CO", 32'(co_w), (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
      chk("CO_SAT", 32'(co_s), (m_cnt > 7) ? 32'd7 : 32'(m_cnt));
      chk("VO_SAT", 32'(vo_s), 32'(m_vo));
   endtask

   // Sends word w so that it appears as w on DO in either bit order.
   task automatic send_word(input logic [7:0] w, input bit f_first,
                            input bit rd_body, input bit rd_last);
      bit b;
      for (int i = 0; i < 8; i++) begin
`ifdef SFQ_PULSE_DESER_MSB_FIRST_EN
         b = w[7-i];
`else
         b = w[i];
`endif
         step(0, b, (i == 0) && f_first, (i == 7) ? rd_last : rd_body);
      end
   endtask

   initial begin
      logic [7:0] s1;
      int         vo_cnt;
      logic [7:0] seen;
      bit         ra, rf, rr, rrst;

      s1 = 8'h8D;   // AI sequence 1,0,1,1,0,0,0,1 as bits 0..7
      ri = 1'b1; ai = 1'b0; fi = 1'b0; rdi = 1'b0;

      // Reset state
      step(1, 0, 0, 0);
      step(1, 1, 1, 1);
      chk("rst_DO", 32'(do_w), 32'h0);
      chk("rst_VO", 32'(vo_w), 32'h0);
      chk("rst_CO", 32'(co_w), 32'h0);

      // Single frame
      for (int i = 0; i < 8; i++) begin
         step(0, s1[i], i == 0, 1);
         if (i == 6) chk("s1_vo_early", 32'(vo_w), 32'h0);
      end
      chk("s1_DO", 32'(do_w), 32'(EXP_S1));
      chk("s1_VO", 32'(vo_w), 32'h1);
      chk("s1_CO", 32'(co_w), 32'd4);
      step(0, 0, 0, 1);
      chk("s1_VO_fall", 32'(vo_w), 32'h0);

      // Backpressure / overflow
      step(1, 0, 0, 0);
      send_word(8'hFF, 1, 0, 0);
      chk("bp_DO1", 32'(do_w), 32'hFF);
      send_word(8'h00, 0, 0, 0);
      chk("bp_DO2", 32'(do_w), 32'hFF);
      chk("bp_OVO", 32'(ovo_w), 32'h1);
      chk("bp_VO", 32'(vo_w), 32'h1);
      chk("sat_CO", 32'(co_s), 32'd7);
      step(0, 0, 0, 1);
      chk("bp_VO_after", 32'(vo_w), 32'h0);

      // Simultaneous accept + complete
      step(1, 0, 0, 0);
      send_word(8'h0F, 1, 0, 0);
      chk("sim_DO1", 32'(do_w), 32'h0F);
      send_word(8'hF0, 0, 0, 1);
      chk("sim_VO", 32'(vo_w), 32'h1);
      chk("sim_DO2", 32'(do_w), 32'hF0);
      chk("sim_OVO", 32'(ovo_w), 32'h0);

      // Resync after 5 bits
      step(1, 0, 0, 0);
      vo_cnt = 0;
      seen = '0;
      for (int i = 0; i < 5; i++) begin
         step(0, 1, i == 0, 1);
         if (vo_w === 1'b1) begin vo_cnt++; seen = do_w; end
      end
      for (int i = 0; i < 8; i++) begin
         step(0, i[0], i == 0, 1);
         if (vo_w === 1'b1) begin vo_cnt++; seen = do_w; end
      end
      chk("rs_count", 32'(vo_cnt), 32'd1);
      chk("rs_DO", 32'(seen), 32'(EXP_RS));

      // Resync on the completing bit emits nothing
      step(1, 0, 0, 0);
      vo_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         step(0, 1, (i == 0) || (i == 7), 1);
         if (vo_w === 1'b1) vo_cnt++;
      end
      chk("rs_last_count", 32'(vo_cnt), 32'd0);

      // Reset mid-word
      step(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, i == 0, 1);
      step(1, 1, 0, 1);
      chk("mw_DO", 32'(do_w), 32'h0);
      chk("mw_VO", 32'(vo_w), 32'h0);
      chk("mw_CO", 32'(co_w), 32'h0);
      vo_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step(0, 1, 0, 1);
         if (vo_w === 1'b1) vo_cnt++;
      end
      chk("mw_idle_vo", 32'(vo_cnt), 32'd0);
      chk("mw_idle_CO", 32'(co_w), 32'h0);

      // Randomised traffic against the model
      for (int i = 0; i < 600; i++) begin
         ra   = bit'($urandom_range(0, 1));
         rf   = ($urandom_range(0, 11) == 0);
         rr   = bit'($urandom_range(0, 1));
         rrst = ($urandom_range(0, 199) == 0);
         step(rrst, ra, rf, rr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
